// File: rtl/hilo_muldiv_pkg.sv
// Shared defines for the HI/LO unit: R-type funct codes and FSM state encodings.
package hilo_muldiv_pkg;

  localparam logic [5:0] MFHI  = 6'h10;
  localparam logic [5:0] MTHI  = 6'h11;
  localparam logic [5:0] MFLO  = 6'h12;
  localparam logic [5:0] MTLO  = 6'h13;
  localparam logic [5:0] MULT  = 6'h18;
  localparam logic [5:0] MULTU = 6'h19;
  localparam logic [5:0] DIV   = 6'h1a;
  localparam logic [5:0] DIVU  = 6'h1b;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_FIX  = 2'd3;

  function automatic logic is_signed_op(input logic [5:0] f);
    return (f == MULT) || (f == DIV);
  endfunction

endpackage

// File: rtl/div_radix2.sv
// Restoring radix-2 divider: one quotient bit per cycle on operand magnitudes,
// sign fixup applied combinationally on the outputs.
module div_radix2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         start,
  input  logic         sgn,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] quo,
  output logic [W-1:0] rem,
  output logic         last
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic          running;
  logic [CW-1:0] cnt;
  logic [W-1:0]  q_r, r_r, d_r;
  logic          neg_q, neg_r;
  logic [W-1:0]  mag_a, mag_b;
  logic [W:0]    shift, diff;

  always_comb begin
    mag_a = (sgn && a[W-1]) ? -a : a;
    mag_b = (sgn && b[W-1]) ? -b : b;
    shift = {r_r, q_r[W-1]};
    diff  = shift - {1'b0, d_r};
  end

  // A zero divisor never borrows, so the quotient fills with ones and the
  // remainder ends up holding the dividend magnitude.
  assign last = running && (cnt == CW'(W - 1));
  assign quo  = neg_q ? -q_r : q_r;
  assign rem  = neg_r ? -r_r : r_r;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      running <= 1'b0;
      cnt     <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      q_r     <= mag_a;
      r_r     <= '0;
      d_r     <= mag_b;
      neg_q   <= sgn && (a[W-1] ^ b[W-1]);
      neg_r   <= sgn && a[W-1];
    end else if (running) begin
      if (!diff[W]) begin
        r_r <= diff[W-1:0];
        q_r <= {q_r[W-2:0], 1'b1};
      end else begin
        r_r <= shift[W-1:0];
        q_r <= {q_r[W-2:0], 1'b0};
      end
      cnt <= cnt + 1'b1;
      if (last) running <= 1'b0;
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// Architectural HI/LO pair with multi-cycle multiply, iterative divide and
// single-cycle MTHI/MTLO, driven from the EX stage.
module hilo_muldiv
  import hilo_muldiv_pkg::*;
#(
  parameter int W       = 32,
  parameter int MUL_LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid,
  input  logic [5:0]   funct,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         flush,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  logic [1:0]     state;
  logic [CW-1:0]  cnt;
  logic           accept, is_mul, is_div, sgn;
  logic [2*W-1:0] ext_a, ext_b, product;
  logic [2*W-1:0] pipe [MUL_LAT];
  logic [W-1:0]   div_quo, div_rem;
  logic           div_last;

  // Handshake: an op is taken on an edge where valid && !busy && !flush;
  // busy comes straight from the state register, so valid never reaches it
  // combinationally and the pipeline must hold the op while busy is high.
  assign busy = (state != ST_IDLE);

  always_comb begin
    accept  = valid && !busy && !flush;
    is_mul  = (funct == MULT) || (funct == MULTU);
    is_div  = (funct == DIV) || (funct == DIVU);
    sgn     = is_signed_op(funct);
    ext_a   = {{W{sgn && a[W-1]}}, a};
    ext_b   = {{W{sgn && b[W-1]}}, b};
    product = ext_a * ext_b;
  end

  div_radix2 #(.W(W)) u_div (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .start (accept && is_div),
    .sgn   (sgn),
    .a     (a),
    .b     (b),
    .quo   (div_quo),
    .rem   (div_rem),
    .last  (div_last)
  );

  // Product registered on accept, then aged through MUL_LAT-1 more stages.
  always_ff @(posedge clk) begin
    if (accept && is_mul) pipe[0] <= product;
    for (int i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (accept) begin
            if (is_mul) state <= ST_MUL;
            else if (is_div) state <= ST_DIV;
            else if (funct == MTHI) hi <= a;
            else if (funct == MTLO) lo <= a;
          end
        end
        ST_MUL: begin
          if (flush) begin
            state <= ST_IDLE;
          end else if (cnt == CW'(MUL_LAT - 1)) begin
            hi    <= pipe[MUL_LAT-1][2*W-1:W];
            lo    <= pipe[MUL_LAT-1][W-1:0];
            done  <= 1'b1;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DIV: begin
          if (flush) state <= ST_IDLE;
          else if (div_last) state <= ST_FIX;
        end
        default: begin
          if (!flush) begin
            hi   <= div_rem;
            lo   <= div_quo;
            done <= 1'b1;
          end
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

- Owns the architectural HI/LO pair for the pipelined MIPS core and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO from the EX stage.
- Generalises single-cycle HI/LO write-enable control into a parametrised multi-cycle unit:
  - configurable data width;
  - configurable multiply latency;
  - iterative signed/unsigned division;
  - a busy/accept handshake that the hazard unit uses to stall dependent instructions;
  - flush support for squashed instructions.

## Interface

Parameters:
- `W`, default 32: operand, HI and LO width.
- `MUL_LAT`, default 2: cycles from multiply accept to the HI/LO write. Must be ≥1.

Ports:
- `clk`, in, 1: single clock; all state updates on rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `valid`, in, 1: EX stage presents an instruction for this unit.
- `funct`, in, 6: R-type funct field; codes come from the shared defines.
- `a`, in, W: rs operand (dividend / multiplicand / MTHI/MTLO source).
- `b`, in, W: rt operand (divisor / multiplier).
- `flush`, in, 1: cancel any in-flight operation.
- `busy`, out, 1: a multiply or divide is in flight; new ops are not accepted.
- `done`, out, 1: one-cycle pulse in the cycle after HI/LO is written by a multiply or divide.
- `hi`, out, W: current HI register.
- `lo`, out, W: current LO register.

## Operation

- Accept rule: an op is accepted at an edge where `valid && !busy && !flush`. While `busy` is high, `valid` is ignored; the pipeline must hold the instruction.
- MTHI / MTLO: on the accept edge, write `a` into HI or LO respectively; `busy` never rises.
- MFHI / MFLO / any other funct: no-op. The pipeline reads `hi`/`lo` directly and must stall MFHI/MFLO while `busy` is high.
- MULT / MULTU: 2W-bit signed or unsigned product. HI gets the upper W bits, LO the lower W bits.
- DIV / DIVU: restoring radix-2, one quotient bit per cycle over W iterations, plus 1 sign-fixup cycle.
  - Signed division works on operand magnitudes.
  - The quotient is negated when the operand signs differ.
  - The remainder takes the sign of the dividend.
  - LO gets the quotient, HI the remainder.
- Divide by zero, decided result: quotient is all ones and remainder equals the dividend, for both signed and unsigned. For DIV the sign fixup is still applied, based on the signs of `a` and `b`.
- Overflow case: most-negative ÷ −1 gives quotient `0x80..0`, remainder 0 (wraps).
- State machine:
  - IDLE: transitions to MUL or DIV on accept.
  - MUL: counts `MUL_LAT` cycles, writes HI/LO on the last one, then returns to IDLE.
  - DIV: runs W iteration cycles, then the FIX cycle, writes HI/LO, then returns to IDLE.
- Operands are captured on the accept edge; later changes on `a`/`b` have no effect.
- Flush:
  - In MUL/DIV: return to IDLE on that edge. HI/LO keep their pre-op values and `done` is not pulsed.
  - In IDLE: blocks acceptance on that edge, including MTHI/MTLO.

## Timing

- Reset: `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE, iteration counter 0. Reset overrides `flush` and `valid`; reset mid-operation abandons it with no HI/LO write.
- Accept edge = E0.
- MTHI/MTLO: new value visible on `hi`/`lo` in the cycle after E0.
- Multiply:
  - `busy`=1 for cycles 1..`MUL_LAT`.
  - HI/LO written at edge E`MUL_LAT`.
  - `done`=1 and `busy`=0 in the following cycle.
- Divide:
  - `busy`=1 for W+1 cycles.
  - HI/LO written at edge E(W+1).
  - `done` pulses in the cycle after E(W+1).
- Back-to-back: a new op may be accepted in the same cycle that `done` is high.
- `busy` is registered; `valid` has no combinational path to `busy`.
- Flush in the final busy cycle still suppresses the write.

## Structure

- Shared defines: funct codes `MULT`, `MULTU`, `DIV`, `DIVU`, `MTHI`, `MTLO`, `MFHI`, `MFLO`, plus state encodings for IDLE/MUL/DIV/FIX. All go in the existing shared defines header.
- Sub-module `div_radix2` holds the iterative divider core:
  - inputs: start, signed flag, operands;
  - outputs: quotient, remainder, last-cycle flag;
  - it is cleared by `rst` or `flush`.
- Multiply is a registered product followed by a (`MUL_LAT`−1)-deep delay line in the top module.

## Test plan

Bench parameters: W=32, MUL_LAT=2.

1. MULT a=`0xFFFFFFFE`, b=3 → HI=`0xFFFFFFFF`, LO=`0xFFFFFFFA`; `busy` high exactly 2 cycles, then a single `done` pulse.
2. MULTU a=`0xFFFFFFFE`, b=3 → HI=`0x00000002`, LO=`0xFFFFFFFA`.
3. DIV a=`0xFFFFFFF9` (−7), b=2 → LO=`0xFFFFFFFD`, HI=`0xFFFFFFFF`; `busy` high 33 cycles; DIV a=`0x80000000`, b=`0xFFFFFFFF` → LO=`0x80000000`, HI=0.
4. DIVU a=7, b=0 → LO=`0xFFFFFFFF`, HI=7; DIV a=`0xFFFFFFF9` (−7), b=0 → LO=1, HI=`0xFFFFFFF9`.
5. Preload HI=`0xAAAA`; start DIVU 100/7; assert `flush` in busy cycle 10 → HI=`0xAAAA` unchanged, `busy`=0 next cycle, no `done`. An MTHI presented together with `flush` while idle is not accepted.
6. MTLO a=`0x1234` while idle → LO=`0x1234` next cycle, `busy` stays 0. During a DIV, `valid` with MTLO `0x5678` is ignored; LO ends at the quotient. `rst` mid-MULT → HI=LO=0, `busy`=0, no `done`.
